// File: rtl/hazard_pkg.sv
// Shared encodings and defaults for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam int unsigned FWD_RF      = 0;
  localparam int unsigned STG_EX      = 0;
  localparam int unsigned STG_MEM     = 1;
  localparam int unsigned STG_WB      = 2;
  localparam int unsigned MUL_LAT_DEF = 2;
  localparam int unsigned DIV_LAT_DEF = 33;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic bubble_ex;
    logic freeze_back;
  } stall_ctrl_t;

  // Memory stall freezes the whole back end; a hazard alone only bubbles EX.
  function automatic stall_ctrl_t stall_decode(input logic mem_stall, input logic hz);
    stall_ctrl_t s;
    s = '0;
    if (mem_stall) begin
      s.stall_if    = 1'b1;
      s.stall_id    = 1'b1;
      s.freeze_back = 1'b1;
    end else if (hz) begin
      s.stall_if  = 1'b1;
      s.stall_id  = 1'b1;
      s.bubble_ex = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// ID-stage operand/producer bus between the pipeline and the hazard controller.
interface hazard_ctrl_unit_if #(
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned PERF_W  = 32
);
  localparam int unsigned FSEL_W = $clog2(NUM_FWD + 1);

  logic [REG_AW-1:0]         id_rs;
  logic [REG_AW-1:0]         id_rt;
  logic                      id_use_rs;
  logic                      id_use_rt;
  logic                      id_hilo_rd;
  logic                      id_md_start;
  logic                      id_md_div;
  logic [NUM_FWD-1:0]        fwd_wen;
  logic [NUM_FWD*REG_AW-1:0] fwd_waddr;
  logic [NUM_FWD-1:0]        fwd_ready;
  logic                      mem_stall;
  logic [FSEL_W-1:0]         id_fwd_a;
  logic [FSEL_W-1:0]         id_fwd_b;
  logic                      stall_if;
  logic                      stall_id;
  logic                      bubble_ex;
  logic                      freeze_back;
  logic                      md_busy;
  logic [PERF_W-1:0]         stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_hilo_rd, id_md_start, id_md_div,
           fwd_wen, fwd_waddr, fwd_ready, mem_stall,
    input  id_fwd_a, id_fwd_b, stall_if, stall_id, bubble_ex, freeze_back, md_busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_hilo_rd, id_md_start, id_md_div,
           fwd_wen, fwd_waddr, fwd_ready, mem_stall,
    output id_fwd_a, id_fwd_b, stall_if, stall_id, bubble_ex, freeze_back, md_busy, stall_cnt
  );

endinterface

// File: rtl/fwd_match.sv
// Single-operand priority matcher: youngest writing stage wins, not-ready winner is a hazard.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned FSEL_W  = $clog2(NUM_FWD + 1)
) (
  input  logic [REG_AW-1:0]         src_i,
  input  logic                      use_i,
  input  logic [NUM_FWD-1:0]        wen_i,
  input  logic [NUM_FWD*REG_AW-1:0] waddr_i,
  input  logic [NUM_FWD-1:0]        ready_i,
  output logic [FSEL_W-1:0]         sel_o,
  output logic                      hazard_o
);

  logic found;

  always_comb begin
    sel_o    = FSEL_W'(FWD_RF);
    hazard_o = 1'b0;
    found    = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (!found && use_i && (src_i != '0) && wen_i[k] &&
          (waddr_i[k*REG_AW +: REG_AW] == src_i)) begin
        found = 1'b1;
        if (ready_i[k]) sel_o = FSEL_W'(k + 1);
        else            hazard_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller: operand bypass selects, mult/div busy tracking, stall counter.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  hazard_ctrl_unit_if.slave ctrl_io
);

  localparam int unsigned FSEL_W = $clog2(NUM_FWD + 1);

  logic              hazard_a, hazard_b;
  logic              md_hz, hz, md_accept;
  stall_ctrl_t       stall;
  logic [CNT_W-1:0]  md_cnt_d, md_cnt_q;
  logic [PERF_W-1:0] stall_cnt_d, stall_cnt_q;

  fwd_match #(
    .NUM_FWD(NUM_FWD),
    .REG_AW (REG_AW),
    .FSEL_W (FSEL_W)
  ) u_match_a (
    .src_i   (ctrl_io.id_rs),
    .use_i   (ctrl_io.id_use_rs),
    .wen_i   (ctrl_io.fwd_wen),
    .waddr_i (ctrl_io.fwd_waddr),
    .ready_i (ctrl_io.fwd_ready),
    .sel_o   (ctrl_io.id_fwd_a),
    .hazard_o(hazard_a)
  );

  fwd_match #(
    .NUM_FWD(NUM_FWD),
    .REG_AW (REG_AW),
    .FSEL_W (FSEL_W)
  ) u_match_b (
    .src_i   (ctrl_io.id_rt),
    .use_i   (ctrl_io.id_use_rt),
    .wen_i   (ctrl_io.fwd_wen),
    .waddr_i (ctrl_io.fwd_waddr),
    .ready_i (ctrl_io.fwd_ready),
    .sel_o   (ctrl_io.id_fwd_b),
    .hazard_o(hazard_b)
  );

  assign ctrl_io.md_busy = (md_cnt_q != '0);
  assign md_hz           = ctrl_io.md_busy & (ctrl_io.id_hilo_rd | ctrl_io.id_md_start);
  assign hz              = hazard_a | hazard_b | md_hz;
  assign md_accept       = ctrl_io.id_md_start & ~hz & ~ctrl_io.mem_stall;

  assign stall               = stall_decode(ctrl_io.mem_stall, hz);
  assign ctrl_io.stall_if    = stall.stall_if;
  assign ctrl_io.stall_id    = stall.stall_id;
  assign ctrl_io.bubble_ex   = stall.bubble_ex;
  assign ctrl_io.freeze_back = stall.freeze_back;
  assign ctrl_io.stall_cnt   = stall_cnt_q;

  // The divider runs on its own, so the countdown continues through memory stalls.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_accept) begin
      md_cnt_d = ctrl_io.id_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctrl_io.mem_stall && hz && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline; successor to the fixed EX/MEM forwarding unit.
- Resolves register operands in ID across NUM_FWD producer stages (EX, MEM, WB, …) using per-stage readiness instead of opcode decoding.
- Tracks the multi-cycle mult/div unit with a busy counter and generates IF/ID hold, EX bubble and global freeze.
- Keeps a saturating hazard-stall performance counter.

Parameters:
NUM_FWD, 3, producer stages visible to ID (index 0 = EX, 1 = MEM, 2 = WB)
REG_AW, 5, register address width
MUL_LAT, 2, cycles HI/LO is busy after mult issue
DIV_LAT, 33, cycles HI/LO is busy after div issue
CNT_W, 6, busy counter width; must hold max(MUL_LAT, DIV_LAT)
PERF_W, 32, stall counter width
(derived) FSEL_W = clog2(NUM_FWD+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs  in  REG_AW  ID source A
id_rt  in  REG_AW  ID source B
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_hilo_rd  in  1  ID is mfhi/mflo
id_md_start  in  1  ID is mult/multu/div/divu
id_md_div  in  1  md op is a divide
fwd_wen  in  NUM_FWD  stage k writes a register
fwd_waddr  in  NUM_FWD*REG_AW  stage k destination, slice k
fwd_ready  in  NUM_FWD  stage k result is valid for bypass (0 for a load still waiting on data)
mem_stall  in  1  memory system not ready
id_fwd_a  out  FSEL_W  operand A select: 0 = regfile, k+1 = stage k
id_fwd_b  out  FSEL_W  operand B select, same encoding
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID
bubble_ex  out  1  load NOP into ID/EX
freeze_back  out  1  hold ID/EX, EX/MEM, MEM/WB
md_busy  out  1  md_cnt != 0
stall_cnt  out  PERF_W  hazard-stall cycles

Behaviour:
- Match, per operand: stage k matches if use = 1, fwd_wen[k] = 1, waddr_k == src, and src != 0. The youngest (lowest k) match wins.
- Forward select: if the winning match has fwd_ready[k] = 1, select = k+1. Otherwise select = 0 and raise a data hazard. With no match, select = 0.
- Register 0 is never forwarded. A zero source address, or use = 0, always gives select 0 and no hazard.
- Data hazard = hazard_a OR hazard_b.
- md hazard = md_busy AND (id_hilo_rd OR id_md_start).
- hz = data hazard OR md hazard.
- Output priority:
  - mem_stall = 1: stall_if = stall_id = freeze_back = 1, bubble_ex = 0. stall_cnt is not incremented.
  - Else hz = 1: stall_if = stall_id = bubble_ex = 1, freeze_back = 0.
  - Else all four are 0.
- All select and stall outputs are combinational from inputs and md_cnt.
- md_cnt (CNT_W bits, registered):
  - Issue is accepted when id_md_start = 1, hz = 0 and mem_stall = 0.
  - On acceptance, md_cnt loads DIV_LAT if id_md_div = 1, else MUL_LAT.
  - Otherwise, if md_cnt != 0, it decrements by 1 every cycle, including during mem_stall, because the divider runs independently.
  - md_busy = (md_cnt != 0).
- stall_cnt: increments by 1 each cycle with mem_stall = 0 and hz = 1, and saturates at all-ones (no wrap).
- Reset (synchronous, rst = 1 at the clk edge):
  - md_cnt = 0 and stall_cnt = 0.
  - Combinational outputs follow from the inputs; with idle inputs, all selects and stalls are 0.
  - Reset mid-divide clears busy immediately in the next cycle.
- Simultaneous events:
  - An md issue is never accepted while busy, since it is stalled by the md hazard.
  - mem_stall masks acceptance.
  - rs == rt both matching is handled independently per operand, with identical selects.

Decomposition:
- Shared package (hazard_pkg): FWD_RF = 0 encoding, stage index constants (STG_EX = 0, STG_MEM = 1, STG_WB = 2), latency defaults.
- One sub-module, fwd_match: a single-operand priority matcher producing sel and hazard, instantiated twice.
- Busy counter and perf counter live in the top module.

Test Plan:
- EX add writes $8 (wen0 = 1, waddr0 = 8, ready0 = 1); ID reads rs = 8 → id_fwd_a = 1, no stall, stall_cnt unchanged.
- Load in EX to $9 (ready0 = 0), ID reads rt = 9 → stall_if = stall_id = bubble_ex = 1, id_fwd_b = 0, stall_cnt +1. Next cycle the load is in MEM with ready1 = 1 → id_fwd_b = 2, no stall.
- Same register in EX (ready) and WB → youngest wins, select = 1. Source $0 with all stages writing $0 → select 0, no stall.
- Div accepted → md_busy = 1 for 33 cycles. mfhi in ID during that window stalls every cycle; on the cycle md_cnt = 0, no stall. mult → 2 busy cycles.
- mem_stall = 1 together with a load-use hazard → freeze_back = 1, bubble_ex = 0, stall_cnt not incremented; md_cnt keeps decrementing.
- rst asserted at md_cnt = 20 → next cycle md_busy = 0 and stall_cnt = 0. Forcing stall_cnt near max then holding hz = 1 → stays at all-ones.
